// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg
//   Shared definitions for the UART echo-path transmit feeder:
//   byte width and the feeder sequencer state encoding.
// ----------------------------------------------------------------------------
package uart_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ASSERT    = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// ----------------------------------------------------------------------------
// byte_fifo
//   Power-of-two byte FIFO with registered occupancy flags and a sticky
//   overflow flag. The read data is read-ahead: o_dout always shows the
//   entry at the read pointer, so a pop consumes the value already visible.
//
// Ports
//   i_clk, i_rst     clock, asynchronous active-high reset
//   i_push, i_din    write strobe and byte (ignored when full -> overflow)
//   i_pop            consume head entry (ignored when empty)
//   o_dout           head entry (mem[rd_ptr])
//   o_count          occupancy 0..DEPTH
//   o_full, o_empty  registered occupancy flags
//   o_overflow       sticky dropped-write flag
//   i_clr_overflow   clears o_overflow; a drop in the same cycle wins
// ----------------------------------------------------------------------------
module byte_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic [BYTE_W-1:0] i_din,
    input  logic              i_pop,
    output logic [BYTE_W-1:0] o_dout,
    output logic [ADDR_W:0]   o_count,
    output logic              o_full,
    output logic              o_empty,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W + 1)'(DEPTH);

    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              push_ok;
    logic              pop_ok;

    always_comb begin
        push_ok  = i_push && !full_q;
        pop_ok   = i_pop && !empty_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        wr_ptr_d = push_ok ? wr_ptr_q + ADDR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop_ok  ? rd_ptr_q + ADDR_W'(1) : rd_ptr_q;
        count_d  = count_q;
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + (ADDR_W + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_W + 1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == DEPTH_CNT);
        empty_d = (count_d == '0);
        // Full is judged before any same-cycle pop, so a write into a full
        // FIFO is dropped even while the head is being consumed.
        ovf_d = ovf_q;
        if (i_push && full_q) begin
            ovf_d = 1'b1;
        end else if (i_clr_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage carries no reset; the pointers define which entries are live.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= i_din;
        end
    end

    assign o_dout     = mem_q[rd_ptr_q];
    assign o_count    = count_q;
    assign o_full     = full_q;
    assign o_empty    = empty_q;
    assign o_overflow = ovf_q;

endmodule

// File: rtl/uart_tx_feeder.sv
// ----------------------------------------------------------------------------
// uart_tx_feeder
//   Elastic buffer between UartRxr and UartTxr. Received byte strobes are
//   queued in byte_fifo; a sequencer hands bytes one at a time to UartTxr
//   using its i_data_valid / o_good_to_reset_dv / o_send_complete handshake,
//   with an optional idle gap after each completed frame.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_wr_valid          one-cycle strobe qualifying i_wr_byte
//   i_wr_byte           byte to enqueue
//   o_byte_to_send      byte for UartTxr, stable while o_data_valid=1
//   o_data_valid        data valid to UartTxr
//   i_good_to_reset_dv  UartTxr has latched the byte
//   i_send_complete     UartTxr stop bit finished
//   o_count             FIFO occupancy 0..DEPTH
//   o_empty, o_full     FIFO occupancy flags
//   o_overflow          sticky: a write was dropped
//   i_clr_overflow      clears o_overflow (a same-cycle drop wins)
// ----------------------------------------------------------------------------
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter  int DEPTH    = 16,
    parameter  int GAP_CLKS = 0,
    localparam int ADDR_W   = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_valid,
    input  logic [BYTE_W-1:0] i_wr_byte,
    output logic [BYTE_W-1:0] o_byte_to_send,
    output logic              o_data_valid,
    input  logic              i_good_to_reset_dv,
    input  logic              i_send_complete,
    output logic [ADDR_W:0]   o_count,
    output logic              o_empty,
    output logic              o_full,
    output logic              o_overflow,
    input  logic              i_clr_overflow
);

    localparam int              GAP_W     = (GAP_CLKS > 1) ? $clog2(GAP_CLKS) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CLKS > 0) ? GAP_CLKS - 1 : 0);
    // Where a finished frame leads: through the gap only when one is configured.
    localparam tx_state_e       DONE_NEXT = (GAP_CLKS > 0) ? S_GAP : S_IDLE;

    tx_state_e         state_q, state_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [BYTE_W-1:0] byte_q, byte_d;
    logic              dv_q, dv_d;
    logic              pop;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_empty;

    byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_push         (i_wr_valid),
        .i_din          (i_wr_byte),
        .i_pop          (pop),
        .o_dout         (fifo_dout),
        .o_count        (o_count),
        .o_full         (o_full),
        .o_empty        (fifo_empty),
        .o_overflow     (o_overflow),
        .i_clr_overflow (i_clr_overflow)
    );

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        byte_d  = byte_q;
        dv_d    = dv_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                // Head byte is read-ahead, so load and pop happen together.
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    byte_d  = fifo_dout;
                    dv_d    = 1'b1;
                    state_d = S_ASSERT;
                end
            end
            S_ASSERT: begin
                if (i_good_to_reset_dv) begin
                    dv_d    = 1'b0;
                    gap_d   = '0;
                    state_d = i_send_complete ? DONE_NEXT : S_WAIT_DONE;
                end
            end
            S_WAIT_DONE: begin
                if (i_send_complete) begin
                    gap_d   = '0;
                    state_d = DONE_NEXT;
                end
            end
            S_GAP: begin
                if (gap_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            byte_q  <= '0;
            dv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            byte_q  <= byte_d;
            dv_q    <= dv_d;
        end
    end

    assign o_byte_to_send = byte_q;
    assign o_data_valid   = dv_q;
    assign o_empty        = fifo_empty;

endmodule

// File: tb/tb_uart_tx_feeder.sv
`timescale 1ns/1ps
module tb_uart_tx_feeder;

    localparam int DEPTH = 16;
    localparam int GAP   = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_valid;
    logic [7:0] wr_byte;
    logic [7:0] byte_to_send;
    logic       dv;
    logic       gtr;
    logic       sc;
    logic [4:0] count;
    logic       empty;
    logic       full;
    logic       ovf;
    logic       clr;

    uart_tx_feeder #(.DEPTH(DEPTH), .GAP_CLKS(GAP)) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_wr_valid         (wr_valid),
        .i_wr_byte          (wr_byte),
        .o_byte_to_send     (byte_to_send),
        .o_data_valid       (dv),
        .i_good_to_reset_dv (gtr),
        .i_send_complete    (sc),
        .o_count            (count),
        .o_empty            (empty),
        .o_full             (full),
        .o_overflow         (ovf),
        .i_clr_overflow     (clr)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    // Reference model: FIFO occupancy, sticky overflow, accepted-byte order.
    int         m_count;
    bit         m_ovf;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];
    bit         dv_prev;
    // Behavioural UartTxr controls.
    bit         stall;
    bit         coinc;
    bit         txr_busy;
    int         txr_t;

    // Behavioural UartTxr: latches a byte when dv is high, reports
    // good_to_reset_dv 2 clocks later and send_complete 10 clocks later.
    initial begin
        gtr = 1'b0; sc = 1'b0; txr_busy = 1'b0; txr_t = 0;
        forever begin
            @(negedge clk);
            gtr = 1'b0; sc = 1'b0;
            if (rst) begin
                txr_busy = 1'b0;
            end else if (!txr_busy) begin
                if (dv) begin
                    txr_busy = 1'b1;
                    txr_t    = 0;
                    rx_q.push_back(byte_to_send);
                end
            end else if (!stall) begin
                txr_t++;
                if (txr_t == 2) begin
                    gtr = 1'b1;
                    if (coinc) begin sc = 1'b1; txr_busy = 1'b0; end
                end else if (txr_t == 10) begin
                    sc = 1'b1; txr_busy = 1'b0;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic reset_model();
        m_count = 0; m_ovf = 1'b0; dv_prev = 1'b0;
        exp_q.delete(); rx_q.delete();
    endtask

    // One clock: drive inputs, let one posedge pass, update the model.
    task automatic step(input logic v, input logic [7:0] b, input logic c);
        bit pop, push_ok;
        wr_valid = v; wr_byte = b; clr = c;
        dv_prev  = dv;
        @(negedge clk); #1;
        pop     = dv && !dv_prev;
        push_ok = v && (m_count < DEPTH);
        if (push_ok) exp_q.push_back(b);
        m_count = m_count + int'(push_ok) - int'(pop);
        if (v && !push_ok) m_ovf = 1'b1;
        else if (c) m_ovf = 1'b0;
        wr_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        @(negedge clk); #1;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic wait_drain(input int bound, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < bound && !ok; i++) begin
            if (m_count == 0 && !dv && !txr_busy && rx_q.size() == exp_q.size()) ok = 1'b1;
            else step(1'b0, 8'h00, 1'b0);
        end
        if (ok) repeat (GAP + 3) step(1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_reset();
        step(1'b1, 8'hA5, 1'b0);
        step(1'b1, 8'h5A, 1'b0);
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if (dv !== 1'b1) begin n_fail++; $display("FAIL t1_pre_dv: got %b expected 1", dv); end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if (dv !== 1'b0) begin n_fail++; $display("FAIL t1_dv: got %b expected 0", dv); end
        n_tests++;
        if (byte_to_send !== 8'h00) begin n_fail++; $display("FAIL t1_byte: got %h expected 00", byte_to_send); end
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL t1_count: got %0d expected 0", count); end
        n_tests++;
        if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL t1_flags: got empty=%b full=%b expected 1/0", empty, full); end
        n_tests++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL t1_ovf: got %b expected 0", ovf); end
        @(negedge clk); #1;
        rst = 1'b0;
        reset_model();
    endtask

    task automatic test_single();
        bit done = 1'b0;
        int bad = 0;
        bit ok;
        reset_model();
        step(1'b1, 8'h41, 1'b0);
        n_tests++;
        if (empty !== 1'b0 || dv !== 1'b0) begin n_fail++; $display("FAIL t2_latency1: got empty=%b dv=%b expected 0/0", empty, dv); end
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if (dv !== 1'b1 || byte_to_send !== 8'h41) begin n_fail++; $display("FAIL t2_load: got dv=%b byte=%h expected 1/41", dv, byte_to_send); end
        for (int i = 0; i < 30 && !done; i++) begin
            if (gtr) begin
                step(1'b0, 8'h00, 1'b0);
                done = 1'b1;
            end else begin
                step(1'b0, 8'h00, 1'b0);
                if (dv !== 1'b1 || byte_to_send !== 8'h41) bad++;
            end
        end
        n_tests++;
        if (!done || dv !== 1'b0) begin n_fail++; $display("FAIL t2_dv_drop: got done=%b dv=%b expected 1/0", done, dv); end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL t2_hold: got %0d bad cycles expected 0", bad); end
        n_tests++;
        if (count !== 5'd0) begin n_fail++; $display("FAIL t2_count: got %0d expected 0", count); end
        wait_drain(100, ok);
        n_tests++;
        if (!ok || rx_q.size() != 1 || rx_q[0] !== 8'h41) begin
            n_fail++; $display("FAIL t2_rx: got ok=%b n=%0d expected 1 byte 41", ok, rx_q.size());
        end
    endtask

    task automatic test_burst();
        int bad = 0;
        bit ok;
        reset_model();
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(8'h30 + i), 1'b0);
            if (count !== m_count[4:0]) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL t3_count: got %0d bad cycles expected 0", bad); end
        wait_drain(1000, ok);
        n_tests++;
        if (!ok || rx_q.size() != 16) begin n_fail++; $display("FAIL t3_drain: got ok=%b n=%0d expected 1/16", ok, rx_q.size()); end
        bad = 0;
        for (int i = 0; i < rx_q.size(); i++) if (rx_q[i] !== 8'(8'h30 + i)) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL t3_order: got %0d misordered expected 0", bad); end
        n_tests++;
        if (ovf !== 1'b0) begin n_fail++; $display("FAIL t3_ovf: got %b expected 0", ovf); end
    endtask

    task automatic test_coincident();
        bit found = 1'b0;
        int edges = 0;
        bit ok;
        reset_model();
        coinc = 1'b1;
        step(1'b1, 8'hC1, 1'b0);
        step(1'b1, 8'hC2, 1'b0);
        for (int i = 0; i < 30 && !found; i++) begin
            if (gtr && sc) found = 1'b1;
            else step(1'b0, 8'h00, 1'b0);
        end
        step(1'b0, 8'h00, 1'b0);
        n_tests++;
        if (!found || dv !== 1'b0) begin n_fail++; $display("FAIL t5_handshake: got found=%b dv=%b expected 1/0", found, dv); end
        for (int i = 1; i <= 12 && edges == 0; i++) begin
            step(1'b0, 8'h00, 1'b0);
            if (dv) edges = i;
        end
        n_tests++;
        if (edges != GAP + 1) begin n_fail++; $display("FAIL t5_gap: got %0d edges expected %0d", edges, GAP + 1); end
        n_tests++;
        if (byte_to_send !== 8'hC2) begin n_fail++; $display("FAIL t5_byte: got %h expected c2", byte_to_send); end
        wait_drain(200, ok);
        n_tests++;
        if (!ok || rx_q.size() != 2 || rx_q[0] !== 8'hC1 || rx_q[1] !== 8'hC2) begin
            n_fail++; $display("FAIL t5_rx: got ok=%b n=%0d expected C1,C2", ok, rx_q.size());
        end
        coinc = 1'b0;
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        int spacing;
        bit ok;
        reset_model();
        for (int i = 0; i < 40; i++) begin
            spacing = $urandom_range(0, 3);
            for (int k = 0; k <= spacing; k++) begin
                step(k == 0, 8'($urandom), 1'b0);
                if (count !== m_count[4:0] || int'(count) > DEPTH ||
                    empty !== (m_count == 0) || full !== (m_count == DEPTH)) bad++;
            end
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL t6_occupancy: got %0d bad cycles expected 0", bad); end
        wait_drain(2000, ok);
        n_tests++;
        if (!ok || rx_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL t6_drain: got ok=%b n=%0d expected %0d", ok, rx_q.size(), exp_q.size());
        end
        bad = 0;
        for (int i = 0; i < rx_q.size() && i < exp_q.size(); i++) if (rx_q[i] !== exp_q[i]) bad++;
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL t6_order: got %0d misordered expected 0", bad); end
        n_tests++;
        if (ovf !== m_ovf) begin n_fail++; $display("FAIL t6_ovf: got %b expected %b", ovf, m_ovf); end
    endtask

    task automatic test_overflow();
        reset_model();
        stall = 1'b1;
        for (int i = 0; i < 18; i++) step(1'b1, 8'(8'h80 + i), 1'b0);
        n_tests++;
        if (count !== 5'd16 || full !== 1'b1) begin n_fail++; $display("FAIL t4_full: got count=%0d full=%b expected 16/1", count, full); end
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL t4_ovf: got %b expected 1", ovf); end
        n_tests++;
        if (dv !== 1'b1 || byte_to_send !== 8'h80) begin n_fail++; $display("FAIL t4_held: got dv=%b byte=%h expected 1/80", dv, byte_to_send); end
        step(1'b1, 8'hEE, 1'b1);
        n_tests++;
        if (ovf !== 1'b1) begin n_fail++; $display("FAIL t4_drop_wins: got %b expected 1", ovf); end
        step(1'b0, 8'h00, 1'b1);
        n_tests++;
        if (ovf !== 1'b0 || full !== 1'b1) begin n_fail++; $display("FAIL t4_clr: got ovf=%b full=%b expected 0/1", ovf, full); end
        stall = 1'b0;
        do_reset();
        n_tests++;
        if (count !== 5'd0 || dv !== 1'b0) begin n_fail++; $display("FAIL t4_reset: got count=%0d dv=%b expected 0/0", count, dv); end
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_byte = 8'h00; clr = 1'b0;
        stall = 1'b0; coinc = 1'b0;
        reset_model();
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        test_reset();
        test_single();
        test_burst();
        test_coincident();
        test_back_to_back();
        test_overflow();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
